// File: rtl/sd_pkg.sv
// Shared types and constants for the SD single-block read controller.
package sd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_R1,
    S_POLL_TOKEN,
    S_READ_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_NOT_READY  = 3'd1,
    ERR_R1         = 3'd2,
    ERR_TIMEOUT    = 3'd3,
    ERR_DATA_TOKEN = 3'd4,
    ERR_SPI        = 3'd5
  } err_code_t;

  localparam logic [7:0]  CMD17       = 8'h51;
  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
  localparam int unsigned BLOCK_LEN   = 512;

  // Sized forms used against the 10-bit byte counter / length port.
  localparam logic [9:0]  BLOCK_LEN_W = 10'(BLOCK_LEN);
  localparam logic [9:0]  READ_BYTES  = 10'(BLOCK_LEN + 2);
  localparam logic [9:0]  LAST_BYTE   = 10'(BLOCK_LEN + 1);

endpackage

// File: rtl/sd_block_read.sv
// SD card single-block (CMD17) read controller driving a byte-level SPI engine.
module sd_block_read
  import sd_pkg::*;
#(
  parameter int unsigned TOKEN_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        card_ready,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_busy,
  output logic        rd_done,
  output logic        rd_error,
  output logic [2:0]  rd_err_code,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [8:0]  data_idx,
  output logic [47:0] spi_cmd_data,
  output logic        spi_cmd,
  output logic [9:0]  spi_bytes_expected,
  input  logic        spi_busy,
  input  logic        spi_error,
  input  logic [7:0]  spi_response,
  input  logic        spi_avail
);

  localparam logic [15:0] POLL_LIMIT = 16'(TOKEN_TIMEOUT);

  state_t      state_q, state_d;
  err_code_t   err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic        pend_q, pend_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic [8:0]  data_idx_q, data_idx_d;

  // A transaction may start only when the engine is free and not faulting.
  logic launch_ok;
  assign launch_ok = !spi_busy && !spi_error;

  // State and datapath registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= S_IDLE;
      err_q        <= ERR_NONE;
      addr_q       <= '0;
      poll_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      pend_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      poll_cnt_q   <= poll_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      pend_q       <= pend_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_idx_q   <= data_idx_d;
    end
  end

  // Next-state and datapath update; pend_q marks a launched transaction awaiting replies.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    addr_d       = addr_q;
    poll_cnt_d   = poll_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    pend_d       = pend_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    data_idx_d   = data_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          if (card_ready) begin
            addr_d  = rd_addr;
            err_d   = ERR_NONE;
            state_d = S_SEND_CMD;
          end else begin
            err_d   = ERR_NOT_READY;
            state_d = S_ERROR;
          end
        end
      end
      S_SEND_CMD: begin
        if (launch_ok) state_d = S_WAIT_R1;
      end
      S_WAIT_R1: begin
        if (spi_avail) begin
          if (spi_response == 8'h00) begin
            poll_cnt_d = '0;
            pend_d     = 1'b0;
            state_d    = S_POLL_TOKEN;
          end else begin
            err_d   = ERR_R1;
            state_d = S_ERROR;
          end
        end
      end
      S_POLL_TOKEN: begin
        if (!pend_q) begin
          if (poll_cnt_q == POLL_LIMIT) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_ERROR;
          end else if (launch_ok) begin
            pend_d = 1'b1;
          end
        end else if (spi_avail) begin
          pend_d = 1'b0;
          if (spi_response == START_TOKEN) begin
            byte_cnt_d = '0;
            state_d    = S_READ_DATA;
          end else if (spi_response == IDLE_BYTE) begin
            poll_cnt_d = poll_cnt_q + 16'd1;
          end else begin
            err_d   = ERR_DATA_TOKEN;
            state_d = S_ERROR;
          end
        end
      end
      S_READ_DATA: begin
        if (!pend_q) begin
          if (launch_ok) pend_d = 1'b1;
        end else if (spi_avail) begin
          if (byte_cnt_q < BLOCK_LEN_W) begin
            data_out_d   = spi_response;
            data_idx_d   = byte_cnt_q[8:0];
            data_valid_d = 1'b1;
          end
          if (byte_cnt_q == LAST_BYTE) begin
            pend_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 10'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Engine fault overrides everything while a transaction sequence is active;
    // DONE/ERROR are single-cycle exits and are left to complete their pulse.
    if (spi_error && (state_q inside {S_SEND_CMD, S_WAIT_R1, S_POLL_TOKEN, S_READ_DATA})) begin
      err_d        = ERR_SPI;
      pend_d       = 1'b0;
      data_valid_d = 1'b0;
      state_d      = S_ERROR;
    end
  end

  // Combinational outputs decoded from the current state.
  always_comb begin
    spi_cmd            = 1'b0;
    spi_cmd_data       = '1;
    spi_bytes_expected = '0;
    unique case (state_q)
      S_SEND_CMD: begin
        spi_cmd            = launch_ok;
        spi_cmd_data       = {CMD17, addr_q, IDLE_BYTE};
        spi_bytes_expected = 10'd1;
      end
      S_POLL_TOKEN: begin
        spi_cmd            = !pend_q && (poll_cnt_q != POLL_LIMIT) && launch_ok;
        spi_bytes_expected = 10'd1;
      end
      S_READ_DATA: begin
        spi_cmd            = !pend_q && launch_ok;
        spi_bytes_expected = READ_BYTES;
      end
      default: ;
    endcase
  end

  assign rd_busy     = (state_q != S_IDLE);
  assign rd_done     = (state_q == S_DONE);
  assign rd_error    = (state_q == S_ERROR);
  assign rd_err_code = err_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign data_idx    = data_idx_q;

endmodule

// File: tb/tb_sd_block_read.sv
// Directed bench for sd_block_read with a scripted SPI engine responder.
`timescale 1ns/1ps
module tb_sd_block_read;

  logic        clk;
  logic        res_n;
  logic        card_ready;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_busy, rd_done, rd_error;
  logic [2:0]  rd_err_code;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [8:0]  data_idx;
  logic [47:0] spi_cmd_data;
  logic        spi_cmd;
  logic [9:0]  spi_bytes_expected;
  logic        spi_busy, spi_error, spi_avail;
  logic [7:0]  spi_response;

  sd_block_read #(.TOKEN_TIMEOUT(8)) dut (
    .clk(clk), .res_n(res_n), .card_ready(card_ready), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_error(rd_error), .rd_err_code(rd_err_code),
    .data_out(data_out), .data_valid(data_valid), .data_idx(data_idx),
    .spi_cmd_data(spi_cmd_data), .spi_cmd(spi_cmd), .spi_bytes_expected(spi_bytes_expected),
    .spi_busy(spi_busy), .spi_error(spi_error), .spi_response(spi_response), .spi_avail(spi_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder script (written by the main sequence only).
  logic [7:0] r1_val;
  logic [7:0] poll_script [8];
  int         poll_len;
  int         err_at;
  logic       resp_abort;

  // Responder observations (written by the responder only).
  int          n_cmd, n_cmd17, n_poll, n_read;
  logic [47:0] cmd17_data;
  logic [9:0]  read_bytes;
  logic        in_read;
  int          cur_byte;

  // Monitor observations (written by the monitor only).
  int dv_cnt, done_cnt, err_cnt, mon_err, last_idx;

  // Scripted SPI engine: launch seen while spi_cmd is high, busy across the transaction, one byte per two cycles.
  initial begin : responder
    logic [47:0] cdata;
    logic [9:0]  nbytes;
    int          kind;
    int          poll_idx;
    logic [31:0] tmp;
    logic [7:0]  b;
    spi_busy = 1'b0; spi_error = 1'b0; spi_avail = 1'b0; spi_response = '0;
    in_read = 1'b0; cur_byte = 0; n_cmd = 0; n_cmd17 = 0; n_poll = 0; n_read = 0;
    cmd17_data = '0; read_bytes = '0; poll_idx = 0;
    forever begin
      @(negedge clk);
      #1;
      while (spi_cmd === 1'b1 && res_n === 1'b1 && !resp_abort) begin
        n_cmd++;
        cdata  = spi_cmd_data;
        nbytes = spi_bytes_expected;
        if (cdata[47:40] == 8'h51) begin
          kind = 0; n_cmd17++; cmd17_data = cdata; poll_idx = 0;
        end else if (nbytes == 10'd1) begin
          kind = 1; n_poll++;
        end else begin
          kind = 2; n_read++; read_bytes = nbytes;
        end
        @(negedge clk);
        spi_busy = 1'b1;
        for (int i = 0; i < int'(nbytes); i++) begin
          if (resp_abort) break;
          @(negedge clk);
          if (kind == 2 && i == err_at) begin
            spi_error = 1'b1;
            @(negedge clk);
            spi_error = 1'b0;
            break;
          end
          if (kind == 0) b = r1_val;
          else if (kind == 1) begin
            b = (poll_idx < poll_len) ? poll_script[poll_idx] : 8'hFF;
            poll_idx++;
          end else begin
            tmp = i;
            b = (i < 512) ? tmp[7:0] : 8'hC3;
          end
          in_read = (kind == 2); cur_byte = i; spi_response = b; spi_avail = 1'b1;
          @(negedge clk);
          spi_avail = 1'b0;
        end
        in_read = 1'b0; spi_avail = 1'b0; spi_busy = 1'b0;
        #1;
      end
    end
  end

  // Output monitor: data_valid must follow an accepted payload byte by exactly one cycle.
  initial begin : monitor
    logic exp_v;
    int   exp_i;
    dv_cnt = 0; done_cnt = 0; err_cnt = 0; mon_err = 0; last_idx = -1;
    forever begin
      @(posedge clk);
      exp_v = res_n && spi_avail && in_read && (cur_byte < 512);
      exp_i = cur_byte;
      #1;
      if (data_valid !== exp_v) mon_err++;
      else if (exp_v && (data_idx !== exp_i[8:0] || data_out !== exp_i[7:0])) mon_err++;
      if (data_valid === 1'b1) begin dv_cnt++; last_idx = int'(data_idx); end
      if (rd_done === 1'b1) done_cnt++;
      if (rd_error === 1'b1) err_cnt++;
    end
  end

  int n_assert, n_fail;
  int b_dv, b_done, b_err, b_mon, b_cmd, b_cmd17, b_poll, b_read;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_dv = dv_cnt; b_done = done_cnt; b_err = err_cnt; b_mon = mon_err;
    b_cmd = n_cmd; b_cmd17 = n_cmd17; b_poll = n_poll; b_read = n_read;
  endtask

  task automatic chk_rst(input string p);
    chk({p, " rd_busy"}, 64'(rd_busy), 0);
    chk({p, " rd_done"}, 64'(rd_done), 0);
    chk({p, " rd_error"}, 64'(rd_error), 0);
    chk({p, " rd_err_code"}, 64'(rd_err_code), 0);
    chk({p, " data_valid"}, 64'(data_valid), 0);
    chk({p, " data_idx"}, 64'(data_idx), 0);
    chk({p, " data_out"}, 64'(data_out), 0);
    chk({p, " spi_cmd"}, 64'(spi_cmd), 0);
    chk({p, " spi_bytes_expected"}, 64'(spi_bytes_expected), 0);
    chk({p, " spi_cmd_data"}, 64'(spi_cmd_data), 64'h0000_FFFF_FFFF_FFFF);
  endtask

  task automatic req(input logic [31:0] a);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (rd_busy === 1'b0) break;
    end
    chk({tag, " completes in budget"}, 64'(k < 5000), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    int k;
    n_assert = 0; n_fail = 0;
    res_n = 1'b0; card_ready = 1'b0; rd_req = 1'b0; rd_addr = '0;
    r1_val = 8'h00; poll_len = 0; err_at = -1; resp_abort = 1'b0;
    foreach (poll_script[i]) poll_script[i] = 8'hFF;

    // Reset values.
    repeat (3) @(negedge clk);
    chk_rst("reset");
    res_n = 1'b1;
    card_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal read at block 0x10: two idle polls then the start token.
    poll_script[0] = 8'hFF; poll_script[1] = 8'hFF; poll_script[2] = 8'hFE; poll_len = 3;
    snap();
    req(32'h0000_0010);
    repeat (40) @(negedge clk);
    chk("nominal busy mid-read", 64'(rd_busy), 1);
    req(32'h0000_DEAD);
    wait_idle("nominal");
    chk("nominal cmd17 frame", 64'(cmd17_data), 64'h0000_5100_0000_10FF);
    chk("nominal cmd17 count", 64'(n_cmd17 - b_cmd17), 1);
    chk("nominal polls", 64'(n_poll - b_poll), 3);
    chk("nominal read txns", 64'(n_read - b_read), 1);
    chk("nominal read length", 64'(read_bytes), 514);
    chk("nominal data_valid count", 64'(dv_cnt - b_dv), 512);
    chk("nominal last data_idx", 64'(last_idx), 511);
    chk("nominal data timing/content", 64'(mon_err - b_mon), 0);
    chk("nominal rd_done", 64'(done_cnt - b_done), 1);
    chk("nominal rd_error", 64'(err_cnt - b_err), 0);
    chk("nominal code", 64'(rd_err_code), 0);

    // R1 reject.
    r1_val = 8'h04;
    snap();
    req(32'h0000_0020);
    wait_idle("r1");
    chk("r1 rd_error", 64'(err_cnt - b_err), 1);
    chk("r1 code", 64'(rd_err_code), 2);
    chk("r1 no read txn", 64'(n_read - b_read), 0);
    chk("r1 no polls", 64'(n_poll - b_poll), 0);
    chk("r1 no data_valid", 64'(dv_cnt - b_dv), 0);
    r1_val = 8'h00;

    // Token timeout: every poll idle.
    poll_len = 0;
    snap();
    req(32'h0000_0030);
    wait_idle("timeout");
    chk("timeout poll count", 64'(n_poll - b_poll), 8);
    chk("timeout rd_error", 64'(err_cnt - b_err), 1);
    chk("timeout code", 64'(rd_err_code), 3);
    chk("timeout no read txn", 64'(n_read - b_read), 0);

    // Data error token.
    poll_script[0] = 8'hFF; poll_script[1] = 8'h08; poll_len = 2;
    snap();
    req(32'h0000_0040);
    wait_idle("token");
    chk("token polls", 64'(n_poll - b_poll), 2);
    chk("token rd_error", 64'(err_cnt - b_err), 1);
    chk("token code", 64'(rd_err_code), 4);

    // SPI fault at payload byte 100.
    poll_script[0] = 8'hFE; poll_len = 1; err_at = 100;
    snap();
    req(32'h0000_0050);
    wait_idle("spifault");
    chk("spifault rd_error", 64'(err_cnt - b_err), 1);
    chk("spifault code", 64'(rd_err_code), 5);
    chk("spifault no rd_done", 64'(done_cnt - b_done), 0);
    chk("spifault data_idx stops", 64'(last_idx <= 99), 1);
    chk("spifault data timing/content", 64'(mon_err - b_mon), 0);
    err_at = -1;

    // Reset asserted at payload byte 300.
    snap();
    req(32'h0000_0060);
    for (k = 0; k < 5000; k++) begin
      @(posedge clk);
      #1;
      if (in_read && cur_byte == 300) break;
    end
    chk("midreset reaches byte 300", 64'(k < 5000), 1);
    @(negedge clk);
    res_n = 1'b0; resp_abort = 1'b1;
    #1;
    chk_rst("midreset");
    repeat (6) @(negedge clk);
    chk("midreset no rd_done", 64'(done_cnt - b_done), 0);
    chk("midreset no rd_error", 64'(err_cnt - b_err), 0);
    resp_abort = 1'b0;
    res_n = 1'b1;
    repeat (2) @(negedge clk);

    // Request while card not ready.
    card_ready = 1'b0;
    snap();
    req(32'h0000_0070);
    wait_idle("notready");
    chk("notready rd_error", 64'(err_cnt - b_err), 1);
    chk("notready code", 64'(rd_err_code), 1);
    chk("notready no spi_cmd", 64'(n_cmd - b_cmd), 0);
    chk("notready no rd_done", 64'(done_cnt - b_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
